// File: rtl/mcs4_pkg.sv
// Shared definitions for the MCS-4 system-side glue logic.
// Holds the 4003 serial loader state encoding and the 4003 stage count.
package mcs4_pkg;

    // Number of stages in one i4003 shift register.
    localparam int I4003_STAGES = 10;

    // Serial loader states:
    //   IDLE   | waiting for a word, cp low, enable high
    //   LOW    | cp low phase, data_out settling toward the next rising edge
    //   HIGH   | cp high phase, 4003 shifts on entry, data_out held
    //   FINISH | one-cycle completion pulse, enable back high
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOW    = 2'd1,
        HIGH   = 2'd2,
        FINISH = 2'd3
    } i4003_state_t;

endpackage

// File: rtl/i4003_cp_timer.sv
// Phase timer for the 4003 shift clock.
// Counts CP_DIV sysclk cycles per cp phase and pulses o_phase_end on the last
// cycle. The count restarts whenever a phase ends or the driver is not shifting,
// so every state change starts a fresh phase.
module i4003_cp_timer #(
    parameter int CP_DIV = 4
) (
    input  logic i_sysclk,
    input  logic i_reset_n,
    input  logic i_run,
    output logic o_phase_end
);

    localparam int PW = (CP_DIV > 1) ? $clog2(CP_DIV) : 1;
    localparam logic [PW-1:0] LAST_CNT = PW'(CP_DIV - 1);

    logic [PW-1:0] r_cnt;

    assign o_phase_end = i_run && (r_cnt == LAST_CNT);

    // Phase counter: cleared outside a transfer and at every phase boundary.
    always_ff @(posedge i_sysclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_cnt <= '0;
        end else if (!i_run || o_phase_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i4003_driver.sv
// Serial loader for an i4003 shift register.
// Takes a parallel word over valid/ready, then shifts it out on data_out with
// generated cp strobes. data_out only moves on the cp falling edge (or on load,
// while cp is low), so the 4003 sees CP_DIV cycles of setup and hold.
// enable is held low while the register contents are in motion.
module i4003_driver
    import mcs4_pkg::*;
#(
    parameter int WIDTH     = I4003_STAGES,
    parameter int CP_DIV    = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             sysclk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             cp,
    output logic             data_out,
    output logic             enable,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    i4003_state_t     r_state;
    i4003_state_t     w_state_nxt;
    logic [WIDTH-1:0] r_sreg;
    logic [BW-1:0]    r_bits;
    logic             w_run;
    logic             w_phase_end;
    logic             w_load;
    logic             w_shift;

    assign w_run = (r_state == LOW) || (r_state == HIGH);

    i4003_cp_timer #(
        .CP_DIV (CP_DIV)
    ) u_cp_timer (
        .i_sysclk    (sysclk),
        .i_reset_n   (reset_n),
        .i_run       (w_run),
        .o_phase_end (w_phase_end)
    );

    // State register; async reset also forces cp low immediately.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic plus load/shift strobes for the datapath.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            IDLE: begin
                if (tx_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = LOW;
                end
            end
            LOW: begin
                if (w_phase_end) begin
                    w_state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (w_phase_end) begin
                    if (r_bits == LAST_BIT) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_shift     = 1'b1;
                        w_state_nxt = LOW;
                    end
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Shift register: loaded on handshake, advanced as cp falls.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_sreg <= '0;
        end else if (w_load) begin
            r_sreg <= tx_data;
        end else if (w_shift) begin
            if (MSB_FIRST) begin
                r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
            end else begin
                r_sreg <= {1'b0, r_sreg[WIDTH-1:1]};
            end
        end
    end

    // Bit counter: number of completed cp pulses that were followed by a shift.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            r_bits <= '0;
        end else if (w_load) begin
            r_bits <= '0;
        end else if (w_shift) begin
            r_bits <= r_bits + 1'b1;
        end
    end

    assign tx_ready = (r_state == IDLE);
    assign cp       = (r_state == HIGH);
    assign busy     = w_run;
    assign enable   = !w_run;
    assign done     = (r_state == FINISH);
    assign data_out = MSB_FIRST ? r_sreg[WIDTH-1] : r_sreg[0];

endmodule

// File: tb/tb_i4003_driver.sv
// Bench for i4003_driver: one default instance (10 bits, CP_DIV=4, MSB first)
// and one small instance (4 bits, CP_DIV=1, LSB first). A monitor per instance
// plays the part of the 4003, capturing data_out on each cp rise and timing
// each transfer; the expected serial word comes from the bit-order rule.
module tb_i4003_driver;

    localparam int WA = 10;
    localparam int DA = 4;
    localparam int WB = 4;
    localparam int DB = 1;

    logic sysclk  = 1'b0;
    logic reset_n = 1'b0;

    logic [WA-1:0] tx_data_a  = '0;
    logic          tx_valid_a = 1'b0;
    logic          tx_ready_a, cp_a, data_out_a, enable_a, busy_a, done_a;

    logic [WB-1:0] tx_data_b  = '0;
    logic          tx_valid_b = 1'b0;
    logic          tx_ready_b, cp_b, data_out_b, enable_b, busy_b, done_b;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 sysclk = ~sysclk;

    always @(posedge sysclk) cyc++;

    i4003_driver #(.WIDTH(WA), .CP_DIV(DA), .MSB_FIRST(1'b1)) u_dut_a (
        .sysclk   (sysclk),
        .reset_n  (reset_n),
        .tx_data  (tx_data_a),
        .tx_valid (tx_valid_a),
        .tx_ready (tx_ready_a),
        .cp       (cp_a),
        .data_out (data_out_a),
        .enable   (enable_a),
        .busy     (busy_a),
        .done     (done_a)
    );

    i4003_driver #(.WIDTH(WB), .CP_DIV(DB), .MSB_FIRST(1'b0)) u_dut_b (
        .sysclk   (sysclk),
        .reset_n  (reset_n),
        .tx_data  (tx_data_b),
        .tx_valid (tx_valid_b),
        .tx_ready (tx_ready_b),
        .cp       (cp_b),
        .data_out (data_out_b),
        .enable   (enable_b),
        .busy     (busy_b),
        .done     (done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Order in which the word's bits reach the 4003, packed first-sent in the MSB.
    function automatic logic [15:0] serial_expect(input logic [15:0] w, input int width,
                                                  input bit msb_first);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < width; i++) begin
            if (msb_first) r[i] = w[i];
            else           r[width-1-i] = w[i];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // ---------------- monitor / 4003 model, instance A ----------------
    int          hs_cyc_a = 0, rise_cyc_a = 0, ncp_a = 0, n_hs_a = 0, n_done_a = 0;
    int          last_lat_a = 0, last_ncp_a = 0, last_done_a = 0, viol_a = 0;
    logic [15:0] bits_a = '0, last_bits_a = '0;
    logic        prev_cp_a = 1'b0, prev_do_a = 1'b0;

    always @(negedge sysclk) begin
        if (reset_n) begin
            if (tx_valid_a && tx_ready_a) begin
                hs_cyc_a = cyc;
                bits_a   = '0;
                ncp_a    = 0;
                n_hs_a++;
            end
            if (cp_a && !prev_cp_a) begin
                if (ncp_a == 0) begin
                    if (cyc != hs_cyc_a + 1 + DA) viol_a++;
                end else if (cyc - rise_cyc_a != 2 * DA) begin
                    viol_a++;
                end
                rise_cyc_a = cyc;
                bits_a     = {bits_a[14:0], data_out_a};
                ncp_a++;
            end
            if (cp_a && (data_out_a != prev_do_a)) viol_a++;
            if (cp_a && !busy_a) viol_a++;
            if (done_a && tx_ready_a) viol_a++;
            if (enable_a == busy_a) viol_a++;
            if (done_a) begin
                last_lat_a  = cyc - hs_cyc_a;
                last_bits_a = bits_a;
                last_ncp_a  = ncp_a;
                last_done_a = cyc;
                n_done_a++;
            end
        end
        prev_cp_a = cp_a;
        prev_do_a = data_out_a;
    end

    // ---------------- monitor / 4003 model, instance B ----------------
    int          hs_cyc_b = 0, rise_cyc_b = 0, ncp_b = 0, n_done_b = 0;
    int          last_lat_b = 0, last_ncp_b = 0, viol_b = 0;
    logic [15:0] bits_b = '0, last_bits_b = '0;
    logic        prev_cp_b = 1'b0, prev_do_b = 1'b0;

    always @(negedge sysclk) begin
        if (reset_n) begin
            if (tx_valid_b && tx_ready_b) begin
                hs_cyc_b = cyc;
                bits_b   = '0;
                ncp_b    = 0;
            end
            if (cp_b && !prev_cp_b) begin
                if (ncp_b == 0) begin
                    if (cyc != hs_cyc_b + 1 + DB) viol_b++;
                end else if (cyc - rise_cyc_b != 2 * DB) begin
                    viol_b++;
                end
                rise_cyc_b = cyc;
                bits_b     = {bits_b[14:0], data_out_b};
                ncp_b++;
            end
            if (cp_b && (data_out_b != prev_do_b)) viol_b++;
            if (cp_b && !busy_b) viol_b++;
            if (done_b && tx_ready_b) viol_b++;
            if (enable_b == busy_b) viol_b++;
            if (done_b) begin
                last_lat_b  = cyc - hs_cyc_b;
                last_bits_b = bits_b;
                last_ncp_b  = ncp_b;
                n_done_b++;
            end
        end
        prev_cp_b = cp_b;
        prev_do_b = data_out_b;
    end

    // ---------------- transfer helpers ----------------
    task automatic wait_idle_a();
        int t;
        t = 0;
        while (!tx_ready_a && t < 400) begin
            tick();
            t++;
        end
        chk("a_idle_reached", tx_ready_a, 1);
    endtask

    task automatic finish_a(input logic [WA-1:0] w, input int nd_before);
        int t;
        t = 0;
        while (n_done_a == nd_before && t < 400) begin
            tick();
            t++;
        end
        chk("a_done_seen", n_done_a != nd_before, 1);
        chk("a_latency", last_lat_a, WA * 2 * DA + 1);
        chk("a_cp_edges", last_ncp_a, WA);
        chk("a_serial_word", last_bits_a, serial_expect(16'(w), WA, 1'b1));
        chk("a_enable_after", enable_a, 1);
        chk("a_invariants", viol_a, 0);
    endtask

    task automatic send_a(input logic [WA-1:0] w);
        int nd0;
        wait_idle_a();
        nd0        = n_done_a;
        tx_data_a  = w;
        tx_valid_a = 1'b1;
        tick();
        tx_valid_a = 1'b0;
        finish_a(w, nd0);
    endtask

    task automatic send_b(input logic [WB-1:0] w);
        int t, nd0;
        t = 0;
        while (!tx_ready_b && t < 100) begin
            tick();
            t++;
        end
        nd0        = n_done_b;
        tx_data_b  = w;
        tx_valid_b = 1'b1;
        tick();
        tx_valid_b = 1'b0;
        t = 0;
        while (n_done_b == nd0 && t < 100) begin
            tick();
            t++;
        end
        chk("b_done_seen", n_done_b != nd0, 1);
        chk("b_latency", last_lat_b, WB * 2 * DB + 1);
        chk("b_cp_edges", last_ncp_b, WB);
        chk("b_serial_word", last_bits_b, serial_expect(16'(w), WB, 1'b0));
        chk("b_invariants", viol_b, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int nd0, nh0, t, d1;

        // Reset held with a word offered: nothing may move.
        reset_n    = 1'b0;
        tx_valid_a = 1'b1;
        tx_data_a  = 10'h3C3;
        tx_valid_b = 1'b1;
        tx_data_b  = 4'hA;
        repeat (4) tick();
        chk("rst_cp", cp_a, 0);
        chk("rst_enable", enable_a, 1);
        chk("rst_tx_ready", tx_ready_a, 1);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_data_out", data_out_a, 0);
        chk("rst_b_cp", cp_b, 0);
        chk("rst_b_enable", enable_b, 1);
        tx_valid_a = 1'b0;
        tx_valid_b = 1'b0;
        reset_n    = 1'b1;
        repeat (3) tick();
        chk("post_rst_idle", busy_a, 0);
        chk("post_rst_no_cp", ncp_a, 0);

        // Single word, default parameters.
        send_a(10'h2B5);
        chk("a_2b5_sequence", last_bits_a, 16'b0000001010110101);

        // Back-to-back with tx_valid held high.
        wait_idle_a();
        nd0        = n_done_a;
        nh0        = n_hs_a;
        tx_data_a  = 10'h3FF;
        tx_valid_a = 1'b1;
        tick();
        tx_data_a  = 10'h000;
        t = 0;
        while (n_hs_a < nh0 + 2 && t < 400) begin
            tick();
            t++;
        end
        tx_valid_a = 1'b0;
        chk("b2b_second_hs", n_hs_a, nh0 + 2);
        chk("b2b_first_word", last_bits_a, 16'h03FF);
        chk("b2b_first_latency", last_lat_a, WA * 2 * DA + 1);
        d1 = last_done_a;
        chk("b2b_gap", hs_cyc_a - d1, 1);
        finish_a(10'h000, nd0 + 1);

        // Word must not be re-sampled while busy.
        wait_idle_a();
        nd0        = n_done_a;
        nh0        = n_hs_a;
        tx_data_a  = 10'h0F0;
        tx_valid_a = 1'b1;
        tick();
        tx_valid_a = 1'b0;
        repeat (20) tick();
        tx_data_a  = 10'h155;
        tx_valid_a = 1'b1;
        repeat (20) tick();
        tx_valid_a = 1'b0;
        finish_a(10'h0F0, nd0);
        chk("busy_single_hs", n_hs_a - nh0, 1);

        // Random words.
        for (int i = 0; i < 6; i++) begin
            send_a(WA'($urandom_range(0, (1 << WA) - 1)));
        end

        // Reset in the middle of a transfer.
        wait_idle_a();
        tx_data_a  = WA'($urandom_range(0, (1 << WA) - 1));
        tx_valid_a = 1'b1;
        tick();
        tx_valid_a = 1'b0;
        t = 0;
        while (ncp_a < 5 && t < 400) begin
            tick();
            t++;
        end
        chk("mid_fifth_rise", ncp_a, 5);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_cp", cp_a, 0);
        chk("mid_rst_enable", enable_a, 1);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_tx_ready", tx_ready_a, 1);
        chk("mid_rst_done", done_a, 0);
        tx_valid_a = 1'b1;
        repeat (3) tick();
        chk("mid_rst_hold_cp", cp_a, 0);
        chk("mid_rst_hold_busy", busy_a, 0);
        tx_valid_a = 1'b0;
        reset_n    = 1'b1;
        tick();
        send_a(10'h1A2);

        // Small LSB-first instance.
        send_b(4'b0011);
        chk("b_0011_sequence", last_bits_b, 16'b1100);
        for (int i = 0; i < 8; i++) begin
            send_b(WB'($urandom_range(0, (1 << WB) - 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
